inst_sequencer: RTL and testbench

INST_SEQUENCER -- requirements
Module: inst_sequencer

---
 rtl/inst_sequencer_pkg.sv | 36 +++
 rtl/acc_addr_gen.sv | 22 ++
 rtl/inst_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_inst_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/inst_sequencer_pkg.sv
// Shared types and constants for the layer instruction sequencer (package seq_pkg).
// Instruction bit positions, the idle word, the state enum and the address constants.
package seq_pkg;

  typedef enum logic [3:0] {
    IDLE, KWR, KLD, AWR, EXEC, DRAIN, OFIFO, ACC, DONE, GAP
  } state_t;

  localparam int IW      = 35;
  localparam int AW      = 11;
  localparam int W_BASE  = 1024;  // weight region in xmem
  localparam int IN_W    = 6;     // input map width
  localparam int K_W     = 3;     // kernel width
  localparam int O_W     = 4;     // output map width
  localparam int GAP_LEN = 10;

  localparam int B_MODE  = 34;
  localparam int B_ACC   = 33;
  localparam int B_CEN_P = 32;
  localparam int B_WEN_P = 31;
  localparam int B_AP_LO = 20;
  localparam int B_CEN_X = 19;
  localparam int B_WEN_X = 18;
  localparam int B_AX_LO = 7;
  localparam int B_OFRD  = 6;
  localparam int B_IFWR  = 5;
  localparam int B_IFRD  = 4;
  localparam int B_L0RD  = 3;
  localparam int B_L0WR  = 2;
  localparam int B_EXEC  = 1;
  localparam int B_LOAD  = 0;

  localparam logic [IW-1:0] IDLE_WORD = (IW'(1) << B_CEN_P) | (IW'(1) << B_WEN_P) |
                                        (IW'(1) << B_CEN_X) | (IW'(1) << B_WEN_X);

endpackage

// File: rtl/acc_addr_gen.sv
// Maps (output position, kernel position) to the psum memory address read during accumulation.
module acc_addr_gen
  import seq_pkg::*;
#(
  parameter int len_nij = 36
) (
  input  logic [3:0]    onij,
  input  logic [3:0]    k,
  output logic [AW-1:0] a_pmem
);

  logic [AW-1:0] orow, ocol, kr, kc;

  always_comb begin
    orow   = AW'(onij) / AW'(O_W);
    ocol   = AW'(onij) % AW'(O_W);
    kr     = AW'(k) / AW'(K_W);
    kc     = AW'(k) % AW'(K_W);
    a_pmem = AW'(k) * AW'(len_nij) + (orow + kr) * AW'(IN_W) + ocol + kc;
  end

endmodule

// File: rtl/inst_sequencer.sv
// Drives the core instruction word through one convolution layer: per-kij weight/activation
// load, execute, drain, psum store, then per-output accumulation. Optional gaps: INST_SEQ_GAP_EN.
module inst_sequencer
  import seq_pkg::*;
#(
  parameter int col      = 8,
  parameter int row      = 8,
  parameter int len_nij  = 36,
  parameter int len_kij  = 9,
  parameter int len_onij = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode_sel,
  output logic [IW-1:0] inst,
  output logic          busy,
  output logic          sfp_clr,
  output logic          onij_valid,
  output logic [3:0]    onij_idx,
  output logic          done
);

  state_t        state, state_d, ret, ret_d, nxt;
  logic [AW-1:0] ph, ph_d, plen, acc_a;
  logic [3:0]    kij, kij_d, onij, onij_d, k_rd;
  logic          mode_q, last;
  logic [IW-1:0] inst_d;
  logic          sfp_d, vld_d, done_d;
  logic [1:0]    vld_pipe;
  logic [1:0][3:0] idx_pipe;

  assign busy       = (state != IDLE);
  assign onij_valid = vld_pipe[1];
  assign onij_idx   = idx_pipe[1];
  assign k_rd       = 4'(ph - AW'(1));

  acc_addr_gen #(.len_nij(len_nij)) u_addr (.onij(onij), .k(k_rd), .a_pmem(acc_a));

  always_comb begin
    case (state)
      KWR, KLD:          plen = AW'(col);
      AWR, EXEC, OFIFO:  plen = AW'(len_nij);
      DRAIN:             plen = AW'(row + col);
      ACC:               plen = AW'(len_kij + 2);  // clr, reads, trailing acc
      GAP:               plen = AW'(GAP_LEN);
      default:           plen = AW'(1);
    endcase
  end

  assign last = (ph == plen - AW'(1));

  always_comb begin
    state_d = state;
    ret_d   = ret;
    nxt     = state;
    ph_d    = ph + AW'(1);
    kij_d   = kij;
    onij_d  = onij;
    inst_d  = IDLE_WORD;
    sfp_d   = 1'b0;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    if (state inside {KWR, KLD, AWR, EXEC, DRAIN, OFIFO, ACC}) inst_d[B_MODE] = mode_q;
    case (state)
      IDLE: begin
        ph_d = '0;
        if (start) begin
          state_d = KWR;
          kij_d   = '0;
          onij_d  = '0;
        end
      end
      KWR: begin
        inst_d[B_CEN_X]        = 1'b0;
        inst_d[B_AX_LO +: AW]  = AW'(W_BASE) + ph;
        inst_d[B_L0WR]         = 1'b1;
        nxt = KLD;
      end
      KLD: begin
        inst_d[B_L0RD] = 1'b1;
        inst_d[B_LOAD] = 1'b1;
        nxt = AWR;
      end
      AWR: begin
        inst_d[B_CEN_X]       = 1'b0;
        inst_d[B_AX_LO +: AW] = ph;
        inst_d[B_L0WR]        = 1'b1;
        nxt = EXEC;
      end
      EXEC: begin
        inst_d[B_L0RD] = 1'b1;
        inst_d[B_EXEC] = 1'b1;
        nxt = DRAIN;
      end
      DRAIN: begin
        inst_d[B_EXEC] = 1'b1;
        nxt = OFIFO;
      end
      OFIFO: begin
        inst_d[B_OFRD]        = 1'b1;
        inst_d[B_CEN_P]       = 1'b0;
        inst_d[B_WEN_P]       = 1'b0;
        inst_d[B_AP_LO +: AW] = AW'(kij) * AW'(len_nij) + ph;
        if (kij < 4'(len_kij - 1)) begin
          nxt = KWR;
          if (last) kij_d = kij + 4'd1;
        end else begin
          nxt = ACC;
          if (last) onij_d = '0;
        end
      end
      ACC: begin
        if (ph == '0) sfp_d = 1'b1;
        if (ph >= AW'(1) && ph <= AW'(len_kij)) begin
          inst_d[B_CEN_P]       = 1'b0;
          inst_d[B_AP_LO +: AW] = acc_a;
        end
        if (ph >= AW'(2)) inst_d[B_ACC] = 1'b1;
        if (last) begin
          ph_d  = '0;
          vld_d = 1'b1;
          if (onij == 4'(len_onij - 1)) state_d = DONE;
          else onij_d = onij + 4'd1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        ph_d    = '0;
        state_d = IDLE;
      end
      GAP: begin
        if (last) begin
          ph_d    = '0;
          state_d = ret;
        end
      end
      default: state_d = IDLE;
    endcase
    // EXEC flows straight into DRAIN; the other load/store phases may be followed by a gap
    if (last && state inside {KWR, KLD, AWR, EXEC, DRAIN, OFIFO}) begin
      ph_d = '0;
`ifdef INST_SEQ_GAP_EN
      if (state != EXEC) begin
        state_d = GAP;
        ret_d   = nxt;
      end else begin
        state_d = nxt;
      end
`else
      state_d = nxt;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ret      <= IDLE;
      ph       <= '0;
      kij      <= '0;
      onij     <= '0;
      mode_q   <= 1'b0;
      inst     <= IDLE_WORD;
      sfp_clr  <= 1'b0;
      done     <= 1'b0;
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      state    <= state_d;
      ret      <= ret_d;
      ph       <= ph_d;
      kij      <= kij_d;
      onij     <= onij_d;
      if (state == IDLE && start) mode_q <= mode_sel;
      inst     <= inst_d;
      sfp_clr  <= sfp_d;
      done     <= done_d;
      // valid trails the registered trailing-acc word by one cycle
      vld_pipe <= {vld_pipe[0], vld_d};
      idx_pipe <= {idx_pipe[0], onij};
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: builds the expected per-cycle output trace of a full
// layer from the phase rules and compares it cycle by cycle, plus reset and abort scenarios.
module tb_inst_sequencer;
  localparam int COL = 8, ROW = 8, NIJ = 36, KIJ = 9, ONIJ = 16;
`ifdef INST_SEQ_GAP_EN
  localparam int GAP = 10;
`else
  localparam int GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, mode_sel;
  logic [34:0] inst;
  logic        busy, sfp_clr, onij_valid, done;
  logic [3:0]  onij_idx;

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [34:0] w;
    bit          sfp;
    bit          vld;
    logic [3:0]  idx;
    bit          dn;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  inst_sequencer #(.col(COL), .row(ROW), .len_nij(NIJ), .len_kij(KIJ), .len_onij(ONIJ)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_sel(mode_sel), .inst(inst), .busy(busy),
    .sfp_clr(sfp_clr), .onij_valid(onij_valid), .onij_idx(onij_idx), .done(done)
  );

  function automatic logic [34:0] w(bit m, bit acc, bit cenp, bit wenp, int ap, bit cenx,
                                    bit wenx, int ax, bit ofrd, bit l0rd, bit l0wr, bit ex, bit ld);
    return {m, acc, cenp, wenp, 11'(ap), cenx, wenx, 11'(ax), ofrd, 2'b00, l0rd, l0wr, ex, ld};
  endfunction

  function automatic logic [34:0] idle_w();
    return w(0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void push(logic [34:0] x, bit s = 0, bit v = 0, int ix = 0, bit d = 0);
    exp_t e;
    e.w = x; e.sfp = s; e.vld = v; e.idx = 4'(ix); e.dn = d;
    q.push_back(e);
  endfunction

  function automatic void gap();
    for (int g = 0; g < GAP; g++) push(idle_w());
  endfunction

  // Expected output words, one per cycle, starting the cycle after start is sampled
  function automatic void build(bit m);
    q.delete();
    for (int kij = 0; kij < KIJ; kij++) begin
      for (int i = 0; i < COL; i++) push(w(m, 0, 1, 1, 0, 0, 1, 1024 + i, 0, 0, 1, 0, 0));
      gap();
      for (int i = 0; i < COL; i++) push(w(m, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 1));
      gap();
      for (int i = 0; i < NIJ; i++) push(w(m, 0, 1, 1, 0, 0, 1, i, 0, 0, 1, 0, 0));
      gap();
      for (int i = 0; i < NIJ; i++) push(w(m, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0));
      for (int i = 0; i < ROW + COL; i++) push(w(m, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0));
      gap();
      for (int i = 0; i < NIJ; i++) push(w(m, 0, 0, 0, kij * NIJ + i, 1, 1, 0, 1, 0, 0, 0, 0));
      gap();
    end
    for (int n = 0; n < ONIJ; n++) begin
      int orr, oc;
      orr = n / 4;
      oc  = n % 4;
      push(w(m, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1, n > 0, n - 1);
      for (int k = 0; k < KIJ; k++)
        push(w(m, k >= 1, 0, 1, k * NIJ + (orr + k / 3) * 6 + oc + k % 3, 1, 1, 0, 0, 0, 0, 0, 0));
      push(w(m, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    end
    push(idle_w(), 0, 1, ONIJ - 1, 1);
  endfunction

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; mode_sel = 1'b0;
    #12;
    n_cmp++; if (inst !== idle_w()) begin n_bad++; $display("FAIL reset_inst got %h want %h", inst, idle_w()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (sfp_clr !== 1'b0) begin n_bad++; $display("FAIL reset_sfp got %b want 0", sfp_clr); end
    n_cmp++; if (onij_valid !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", onij_valid); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_layer(input bit spur);
    bit m;
    int bcnt, bexp;
    m = 1'($urandom % 2);
    build(m);
    bexp = KIJ * (2 * COL + 3 * NIJ + ROW + COL + 5 * GAP) + ONIJ * (KIJ + 2) + 1;
    @(negedge clk) begin mode_sel = m; start = 1'b1; end
    @(posedge clk); #1;
    start = 1'b0; mode_sel = ~m;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL start_busy got %b want 1", busy); end
    n_cmp++; if (inst !== idle_w()) begin n_bad++; $display("FAIL start_inst got %h want %h", inst, idle_w()); end
    bcnt = 1;
    for (int j = 0; j < q.size(); j++) begin
      start = spur && (j < q.size() - 5) && (($urandom % 16 == 0) || j == 90);
      @(posedge clk); #1;
      if (busy) bcnt++;
      n_cmp++;
      if (inst !== q[j].w) begin
        n_bad++; $display("FAIL trace_inst cyc %0d got %h want %h", j, inst, q[j].w);
      end
      n_cmp++;
      if ({sfp_clr, onij_valid, done} !== {q[j].sfp, q[j].vld, q[j].dn}) begin
        n_bad++;
        $display("FAIL trace_flags cyc %0d got sfp/vld/done %b%b%b want %b%b%b", j,
                 sfp_clr, onij_valid, done, q[j].sfp, q[j].vld, q[j].dn);
      end
      if (q[j].vld) begin
        n_cmp++;
        if (onij_idx !== q[j].idx) begin
          n_bad++; $display("FAIL trace_idx cyc %0d got %0d want %0d", j, onij_idx, q[j].idx);
        end
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, onij_valid} !== 3'b000 || inst !== idle_w()) begin
      n_bad++; $display("FAIL post_idle got busy/done/vld %b%b%b inst %h want 000 %h",
                        busy, done, onij_valid, inst, idle_w());
    end
    n_cmp++;
    if (bcnt != bexp) begin n_bad++; $display("FAIL busy_len got %0d want %0d", bcnt, bexp); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk) begin mode_sel = 1'b1; start = 1'b1; end
    @(posedge clk); #1 start = 1'b0;
    repeat (60 + 3 * GAP) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (inst !== idle_w()) begin n_bad++; $display("FAIL abort_inst got %h want %h", inst, idle_w()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    n_cmp++; if (sfp_clr !== 1'b0) begin n_bad++; $display("FAIL abort_sfp got %b want 0", sfp_clr); end
    @(negedge clk) begin reset = 1'b1; mode_sel = 1'b0; start = 1'b1; end
    @(posedge clk); #1 start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy got %b want 1", busy); end
    @(posedge clk); #1;
    n_cmp++;
    if (inst !== w(0, 0, 1, 1, 0, 0, 1, 1024, 0, 0, 1, 0, 0)) begin
      n_bad++; $display("FAIL restart_kwr0 got %h want %h", inst, w(0, 0, 1, 1, 0, 0, 1, 1024, 0, 0, 1, 0, 0));
    end
    @(posedge clk); #1;
    n_cmp++;
    if (inst !== w(0, 0, 1, 1, 0, 0, 1, 1025, 0, 0, 1, 0, 0)) begin
      n_bad++; $display("FAIL restart_kwr1 got %h want %h", inst, w(0, 0, 1, 1, 0, 0, 1, 1025, 0, 0, 1, 0, 0));
    end
    #2 reset = 1'b0;
    #3;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort2_busy got %b want 0", busy); end
    @(negedge clk) reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_layer(1'b0);
    test_layer(1'b1);
    test_mid_reset();
    test_layer(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
